dmem_uart_dump: RTL and testbench



---
 rtl/dmem_uart_dump.sv | 182 ++++++++++++++++++
 tb/tb_dmem_uart_dump.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_uart_dump.sv
// ---------------------------------------------------------------------------
// dmem_uart_dump
//
// Purpose:
//   Streams the whole data memory out of a UART TX pin, one word at a time.
//   The host receives a sync byte followed by every word, high byte first.
//   Each byte is sent as an 8N1 frame, and frames follow each other with no
//   idle gap. Words are read through the core's data-memory debug port. Each
//   word is latched once, just before its high byte starts, so that a slow
//   (registered) debug read has plenty of time to settle.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset; aborts a dump in progress
//   start      - request a dump (only looked at while idle, never queued)
//   debug_addr - word address driven to the data-memory debug port
//   debug_data - word returned by the debug port
//   tx         - UART serial output, idles high
//   busy       - high for the whole duration of a dump
//   done       - single-cycle pulse after the last stop bit
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per UART bit (must be >= 2)
//   ADDR_W       - debug address width
//   DATA_W       - debug data width (the byte split assumes 16)
//   NUM_WORDS    - number of words dumped, 1..2**ADDR_W
//   SYNC_BYTE    - first byte of every dump
// ---------------------------------------------------------------------------
module dmem_uart_dump #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          ADDR_W       = 7,
  parameter int          DATA_W       = 16,
  parameter int          NUM_WORDS    = 128,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  // Bit positions inside a frame: 0 is the start bit, 1..8 are the data
  // bits and 9 is the stop bit.
  localparam logic [3:0] BIT_LAST_DATA = 4'd8;
  localparam logic [3:0] BIT_STOP      = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_t;

  // Which byte of the stream is currently on the wire.
  typedef enum logic [1:0] {
    BYTE_SYNC,
    BYTE_HI,
    BYTE_LO
  } byte_kind_t;

  state_t            state;
  byte_kind_t        byte_kind;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] word_reg;
  logic              last_word;
  logic [7:0]        cur_byte;

  // The byte being serialised. It comes straight from the captured word
  // (or the sync constant), so later changes on debug_data cannot alter a
  // byte that is already in flight.
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_kind)
      BYTE_HI: cur_byte = word_reg[DATA_W-1 -: 8];
      BYTE_LO: cur_byte = word_reg[7:0];
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  // Single FSM with registered outputs.
  //
  // The baud counter runs once per bit. When it wraps, tx is loaded with
  // the level of the next bit, so every bit lasts exactly CLKS_PER_BIT
  // cycles. The stop bit of one byte is followed directly by the start bit
  // of the next byte, which keeps the frames back to back.
  //
  // Address and data sequencing:
  //  - The end of a SYNC or LO byte is the capture point for the next word.
  //    At that point the address has been stable for a full frame.
  //  - The end of a HI byte advances the address. The next word's read
  //    therefore has the whole LO frame to complete.
  //  - On the last word the address stays where it is, and last_word marks
  //    that the following LO byte finishes the dump.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      byte_kind  <= BYTE_SYNC;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      word_reg   <= '0;
      last_word  <= 1'b0;
      debug_addr <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SEND;
            byte_kind  <= BYTE_SYNC;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            last_word  <= 1'b0;
            debug_addr <= '0;
            tx         <= 1'b0;
            busy       <= 1'b1;
          end
        end

        ST_SEND: begin
          if (baud_cnt != BAUD_LAST) begin
            baud_cnt <= baud_cnt + 1'b1;
          end else begin
            baud_cnt <= '0;
            if (bit_cnt < BIT_LAST_DATA) begin
              // Leaving the start bit or a data bit: put the next data bit
              // on the wire.
              tx      <= cur_byte[bit_cnt[2:0]];
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt == BIT_LAST_DATA) begin
              tx      <= 1'b1;
              bit_cnt <= BIT_STOP;
            end else begin
              // End of the stop bit: either start the next byte or finish.
              bit_cnt <= '0;
              if (byte_kind == BYTE_HI) begin
                tx        <= 1'b0;
                byte_kind <= BYTE_LO;
                if (debug_addr == LAST_ADDR) begin
                  last_word <= 1'b1;
                end else begin
                  debug_addr <= debug_addr + 1'b1;
                end
              end else if (byte_kind == BYTE_LO && last_word) begin
                state      <= ST_DONE;
                tx         <= 1'b1;
                busy       <= 1'b0;
                done       <= 1'b1;
                debug_addr <= '0;
              end else begin
                tx        <= 1'b0;
                word_reg  <= debug_data;
                byte_kind <= BYTE_HI;
              end
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_uart_dump.sv
// ---------------------------------------------------------------------------
// tb_dmem_uart_dump
//
// Purpose:
//   Self-checking bench for dmem_uart_dump, using a short bit time and a
//   four-word memory. The memory model answers the debug port one cycle
//   after the address, as a registered read would.
//
//   The reference builds the expected byte list from the memory contents.
//   From that list and the frame layout it derives, for every cycle of a
//   dump, the expected tx level, the expected debug address and the expected
//   busy/done values. The tx line is also decoded back into bytes at
//   mid-bit and compared against the same list.
// ---------------------------------------------------------------------------
module tb_dmem_uart_dump;

  localparam int CPB    = 4;
  localparam int NW     = 4;
  localparam int ADDR_W = 7;
  localparam int FRAME  = 10 * CPB;
  localparam int NBYTES = 1 + 2 * NW;
  localparam int B      = NBYTES * FRAME;

  localparam int MODE_PLAIN  = 0;
  localparam int MODE_MEMCHG = 1;
  localparam int MODE_PULSES = 2;
  localparam int MODE_HOLD   = 3;
  localparam int MODE_RESET  = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] debug_addr;
  logic [15:0]       debug_data;
  logic              tx;
  logic              busy;
  logic              done;

  logic [15:0] mem [NW];

  int n_tests;
  int n_fail;

  dmem_uart_dump #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W),
    .DATA_W      (16),
    .NUM_WORDS   (NW),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .debug_addr(debug_addr),
    .debug_data(debug_data),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered debug read port. Addresses outside the memory return a
  // marker value.
  always @(posedge clk) begin
    if (int'(debug_addr) < NW) debug_data <= mem[int'(debug_addr)];
    else                       debug_data <= 16'hDEAD;
  end

  task automatic load_default_mem();
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    mem[2] = 16'h0000;
    mem[3] = 16'hFFFF;
  endtask

  // Checks the idle/reset output values and reports any difference.
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (i == 3) reset = 1'b0;
      n_tests++;
      if ({tx, busy, done} !== 3'b100 || debug_addr !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_values cycle %0d: tx/busy/done=%b%b%b addr=%0d, expected 100 addr=0",
                 i, tx, busy, done, debug_addr);
      end
    end
  endtask

  // Checks the first frame bit by bit against fixed constants, then aborts
  // the dump with reset.
  task automatic test_sync_frame();
    logic [7:0] sync_bits;
    logic       exp_tx;
    sync_bits = 8'hA5;
    repeat (2) @(negedge clk);
    start = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j <= 4)       exp_tx = 1'b0;
      else if (j <= 36) exp_tx = sync_bits[(j - 5) / 4];
      else              exp_tx = 1'b1;
      n_tests++;
      if (tx !== exp_tx) begin
        n_fail++;
        $display("[TB] FAIL sync_frame T+%0d: tx=%b expected %b", j, tx, exp_tx);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one dump and checks it cycle by cycle against the reference.
  // ev_cycle is the T-relative cycle of the scenario event:
  //   MODE_MEMCHG - mem[1] changes to new_w1
  //   MODE_RESET  - reset is asserted
  task automatic run_dump(input string name, input int mode, input int ev_cycle,
                          input logic [15:0] new_w1);
    logic [15:0]       words [NW];
    logic [7:0]        exp_bytes [NBYTES];
    logic [7:0]        got [$];
    logic [7:0]        shreg;
    logic              exp_tx;
    logic [ADDR_W-1:0] exp_addr;
    int                last_j, c, b, bit_i, wi;

    // Word k is latched at the end of byte 2k, which is cycle (2k+1)*FRAME.
    // A registered read means that a memory change made in an earlier cycle
    // is seen at that point.
    for (int k = 0; k < NW; k++) words[k] = mem[k];
    if (mode == MODE_MEMCHG && ev_cycle < 3 * FRAME) words[1] = new_w1;
    exp_bytes[0] = 8'hA5;
    for (int k = 0; k < NW; k++) begin
      exp_bytes[1 + 2 * k] = words[k][15:8];
      exp_bytes[2 + 2 * k] = words[k][7:0];
    end

    if (mode == MODE_HOLD)       last_j = B + 3;
    else if (mode == MODE_RESET) last_j = ev_cycle + 1;
    else                         last_j = B + 2;

    shreg = 8'h00;
    repeat (2) @(negedge clk);
    start = 1'b1;
    for (int j = 1; j <= last_j; j++) begin
      @(negedge clk);
      if (mode != MODE_HOLD) start = (mode == MODE_PULSES && (j == 50 || j == 200));
      if (mode == MODE_MEMCHG && j == ev_cycle) mem[1] = new_w1;

      if (mode == MODE_RESET && j == ev_cycle + 1) begin
        n_tests++;
        if ({tx, busy, done} !== 3'b100 || debug_addr !== '0) begin
          n_fail++;
          $display("[TB] FAIL %s abort T+%0d: tx/busy/done=%b%b%b addr=%0d, expected 100 addr=0",
                   name, j, tx, busy, done, debug_addr);
        end
        reset = 1'b0;
      end else if (j <= B) begin
        c     = j - 1;
        b     = c / FRAME;
        bit_i = (c % FRAME) / CPB;
        if (bit_i == 0)      exp_tx = 1'b0;
        else if (bit_i == 9) exp_tx = 1'b1;
        else                 exp_tx = exp_bytes[b][bit_i - 1];
        if (b == 0)          wi = 0;
        else if (b % 2 == 1) wi = (b - 1) / 2;
        else                 wi = (b / 2 > NW - 1) ? NW - 1 : b / 2;
        exp_addr = ADDR_W'(wi);

        n_tests++;
        if (tx !== exp_tx) begin
          n_fail++;
          $display("[TB] FAIL %s tx T+%0d: got %b expected %b", name, j, tx, exp_tx);
        end
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL %s busy T+%0d: got %b expected 1", name, j, busy);
        end
        n_tests++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL %s done T+%0d: got %b expected 0", name, j, done);
        end
        n_tests++;
        if (debug_addr !== exp_addr) begin
          n_fail++;
          $display("[TB] FAIL %s addr T+%0d: got %0d expected %0d", name, j, debug_addr, exp_addr);
        end

        if (c % CPB == CPB / 2) begin
          if (bit_i >= 1 && bit_i <= 8) shreg[bit_i - 1] = tx;
          if (bit_i == 9) got.push_back(shreg);
        end
        if (mode == MODE_RESET && j == ev_cycle) reset = 1'b1;
      end else if (j == B + 1) begin
        n_tests++;
        if ({tx, busy, done} !== 3'b101 || debug_addr !== '0) begin
          n_fail++;
          $display("[TB] FAIL %s done_cycle T+%0d: tx/busy/done=%b%b%b addr=%0d, expected 101 addr=0",
                   name, j, tx, busy, done, debug_addr);
        end
      end else if (j == B + 2) begin
        n_tests++;
        if ({tx, busy, done} !== 3'b100) begin
          n_fail++;
          $display("[TB] FAIL %s idle_after T+%0d: tx/busy/done=%b%b%b expected 100",
                   name, j, tx, busy, done);
        end
      end else begin
        n_tests++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL %s restart T+%0d: tx=%b busy=%b expected tx=0 busy=1",
                   name, j, tx, busy);
        end
        start = 1'b0;
        reset = 1'b1;
      end
    end

    if (mode == MODE_HOLD) begin
      @(negedge clk);
      reset = 1'b0;
    end

    if (mode != MODE_RESET) begin
      n_tests++;
      if (got.size() != NBYTES) begin
        n_fail++;
        $display("[TB] FAIL %s byte_count: got %0d expected %0d", name, got.size(), NBYTES);
      end else begin
        for (int i = 0; i < NBYTES; i++) begin
          n_tests++;
          if (got[i] !== exp_bytes[i]) begin
            n_fail++;
            $display("[TB] FAIL %s byte %0d: got %h expected %h", name, i, got[i], exp_bytes[i]);
          end
        end
      end
    end
  endtask

  task automatic test_full_dump();
    load_default_mem();
    run_dump("full_dump", MODE_PLAIN, 0, 16'h0000);
  endtask

  // Byte 3 is hi(w1) and covers T+121..T+160; w1 is latched at T+120.
  task automatic test_capture_isolation();
    load_default_mem();
    run_dump("capture_late", MODE_MEMCHG, 140, 16'h5555);
    load_default_mem();
    run_dump("capture_early", MODE_MEMCHG, 100, 16'h5555);
    load_default_mem();
  endtask

  task automatic test_start_while_busy();
    load_default_mem();
    run_dump("start_pulses", MODE_PULSES, 0, 16'h0000);
  endtask

  task automatic test_start_held();
    load_default_mem();
    run_dump("start_held", MODE_HOLD, 0, 16'h0000);
  endtask

  task automatic test_reset_mid_dump();
    load_default_mem();
    run_dump("reset_mid", MODE_RESET, 130, 16'h0000);
    run_dump("after_reset", MODE_PLAIN, 0, 16'h0000);
  endtask

  task automatic test_random_contents();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NW; k++) mem[k] = 16'($urandom);
      run_dump("random", MODE_PLAIN, 0, 16'h0000);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    load_default_mem();

    test_reset();
    test_sync_frame();
    test_full_dump();
    test_capture_isolation();
    test_start_while_busy();
    test_start_held();
    test_reset_mid_dump();
    test_random_contents();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
